obi_mem_responder: RTL and testbench

Single-port OBI responder (memory-side end of the core instruction/data OBI interface) backing a word-addressed SRAM model with programmable grant wait states and fixed response latency. It sits on a bus port or directly on a core's `obi_req_t`/`obi_resp_t` pair. It is used as a boot/scratch memory in simulation and as a protocol-compliant target for exercising initiator stall handling.

---
 rtl/obi_mem_responder.sv | 97 +++++++++
 tb/tb_obi_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// ============================================================================
// obi_mem_responder : OBI SRAM target with grant wait states and fixed
// response latency.                                         Rev 1.0
// ============================================================================
`default_nettype none

package obi_mem_responder_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int NUM_WORDS    = 1024,
  parameter int GNT_WAIT     = 0,
  parameter int RESP_LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o
);

  localparam int c_IDX_W = $clog2(NUM_WORDS);

  logic [c_IDX_W-1:0]      w_idx;
  logic                    w_gnt;
  logic [31:0]             w_bmask;
  logic [31:0]             w_rdata;
  logic [31:0]             w_wword;
  logic                    w_unused;
  logic [3:0]              r_wcnt;
  logic [31:0]             r_mem [NUM_WORDS];
  logic [RESP_LATENCY-1:0] r_vld;
  logic [31:0]             r_dat [RESP_LATENCY];

  assign w_idx    = obi_req_i.addr[c_IDX_W+1:2];
  assign w_gnt    = rst_ni && obi_req_i.req && (r_wcnt == 4'(GNT_WAIT));
  assign w_bmask  = {{8{obi_req_i.be[3]}}, {8{obi_req_i.be[2]}},
                     {8{obi_req_i.be[1]}}, {8{obi_req_i.be[0]}}};
  assign w_rdata  = obi_req_i.we ? 32'h0 : r_mem[w_idx];
  assign w_wword  = (r_mem[w_idx] & ~w_bmask) | (obi_req_i.wdata & w_bmask);
  // Upper address bits alias onto the array; byte offset is ignored.
  assign w_unused = ^{obi_req_i.addr[31:c_IDX_W+2], obi_req_i.addr[1:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wcnt <= '0;
    end else if (!obi_req_i.req || w_gnt) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_gnt && obi_req_i.we) begin
      r_mem[w_idx] <= w_wword;
    end
  end

  // Non-stalling response shift register; stage 0 loads on acceptance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vld <= '0;
      for (int s = 0; s < RESP_LATENCY; s++) begin
        r_dat[s] <= '0;
      end
    end else begin
      r_vld[0] <= w_gnt;
      r_dat[0] <= w_gnt ? w_rdata : 32'h0;
      for (int s = 1; s < RESP_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_dat[s] <= r_dat[s-1];
      end
    end
  end

  assign obi_resp_o = '{gnt:    w_gnt,
                        rvalid: r_vld[RESP_LATENCY-1],
                        rdata:  r_dat[RESP_LATENCY-1]};

endmodule

`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
// ============================================================================
// tb_obi_mem_responder : four responder configurations driven concurrently,
// checked against a transaction-level model.                Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_obi_mem_responder;
  import obi_mem_responder_pkg::*;

  localparam int N_CFG = 4;
  localparam int NRAND = 400;

  function automatic int nw_of(input int k);
    case (k)
      0:       return 1024;
      1:       return 256;
      2:       return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int gw_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic int rl_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  logic      clk = 1'b0;
  int        cyc = 0;
  obi_req_t  bus_req [N_CFG];
  obi_resp_t bus_rsp [N_CFG];
  logic      rst_n   [N_CFG];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N_CFG; g++) begin : g_dut
    obi_mem_responder #(
      .NUM_WORDS   (nw_of(g)),
      .GNT_WAIT    (gw_of(g)),
      .RESP_LATENCY(rl_of(g))
    ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n[g]),
      .obi_req_i (bus_req[g]),
      .obi_resp_o(bus_rsp[g])
    );
  end

  int vectors = 0;
  int errors  = 0;

  function automatic void chk(input string name, input int k,
                              input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d cyc%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endfunction

  // Reference model: memory image, wait count, responses keyed by due cycle.
  logic [31:0] mmem  [N_CFG][1024];
  int          waited[N_CFG];
  bit          exp_v [N_CFG][8];
  logic [31:0] exp_d [N_CFG][8];
  bit          live  [N_CFG];
  int          log_c [$];
  logic [31:0] log_d [$];
  bit          log_on = 1'b0;

  always @(negedge clk) begin
    int          slot;
    int          idx;
    logic        eg;
    logic [31:0] d;
    for (int k = 0; k < N_CFG; k++) begin
      slot = cyc % 8;
      eg   = rst_n[k] && bus_req[k].req && (waited[k] == gw_of(k));
      if (live[k]) begin
        chk("gnt", k, 32'(bus_rsp[k].gnt), 32'(eg));
        chk("rvalid", k, 32'(bus_rsp[k].rvalid), 32'(exp_v[k][slot]));
        if (exp_v[k][slot]) chk("rdata", k, bus_rsp[k].rdata, exp_d[k][slot]);
      end
      if (k == 2 && log_on && bus_rsp[2].rvalid) begin
        log_c.push_back(cyc);
        log_d.push_back(bus_rsp[2].rdata);
      end
      exp_v[k][slot] = 1'b0;
      if (!rst_n[k]) begin
        waited[k] = 0;
        for (int s = 0; s < 8; s++) exp_v[k][s] = 1'b0;
        live[k] = 1'b1;
      end else if (eg) begin
        idx = int'((bus_req[k].addr >> 2) % 32'(nw_of(k)));
        d   = bus_req[k].we ? 32'h0 : mmem[k][idx];
        if (bus_req[k].we) begin
          for (int b = 0; b < 4; b++)
            if (bus_req[k].be[b]) mmem[k][idx][8*b +: 8] = bus_req[k].wdata[8*b +: 8];
        end
        exp_v[k][(cyc + rl_of(k)) % 8] = 1'b1;
        exp_d[k][(cyc + rl_of(k)) % 8] = d;
        waited[k] = 0;
      end else if (bus_req[k].req) begin
        waited[k]++;
      end else begin
        waited[k] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until granted; returns at the cycle after acceptance.
  task automatic txn(input int k, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    bus_req[k].req   = 1'b1;
    bus_req[k].we    = we;
    bus_req[k].addr  = addr;
    bus_req[k].wdata = wdata;
    bus_req[k].be    = be;
    while (!got && waits <= 40) begin
      @(negedge clk);
      if (bus_rsp[k].gnt === 1'b1) got = 1'b1;
      else waits++;
    end
    if (!got) chk("gnt_timeout", k, 32'(waits), 32'(gw_of(k)));
    step();
    bus_req[k].req = 1'b0;
  endtask

  task automatic run_cfg(input int k);
    int          w;
    int          s;
    int          nw;
    logic [31:0] a;
    nw = nw_of(k);
    rst_n[k] = 1'b0;
    repeat (2) step();
    rst_n[k] = 1'b1;
    @(negedge clk);
    chk("rst_rvalid", k, 32'(bus_rsp[k].rvalid), 32'h0);
    chk("rst_rdata", k, bus_rsp[k].rdata, 32'h0);
    step();

    // Fill every word, using aliased addresses with random upper/offset bits.
    for (int i = 0; i < nw; i++) begin
      a = ($urandom / 32'(nw * 4)) * 32'(nw * 4) + 32'(i * 4) + 32'($urandom_range(0, 3));
      txn(k, 1'b1, a, $urandom, 4'hF, w);
    end
    repeat (5) step();

    case (k)
      0: begin
        txn(k, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, w);
        chk("wr_gnt_wait", k, 32'(w), 32'h0);
        txn(k, 1'b0, 32'h10, 32'h0, 4'hF, w);
        chk("rd_gnt_wait", k, 32'(w), 32'h0);
        @(negedge clk);
        chk("raw_rvalid", k, 32'(bus_rsp[k].rvalid), 32'h1);
        chk("raw_rdata", k, bus_rsp[k].rdata, 32'hDEADBEEF);
        step();
        txn(k, 1'b1, 32'h14, 32'h11223344, 4'hF, w);
        txn(k, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, w);
        @(negedge clk);
        chk("wr_rvalid", k, 32'(bus_rsp[k].rvalid), 32'h1);
        chk("wr_rdata", k, bus_rsp[k].rdata, 32'h0);
        step();
        txn(k, 1'b0, 32'h14, 32'h0, 4'hF, w);
        @(negedge clk);
        chk("be_rdata", k, bus_rsp[k].rdata, 32'h11BB33DD);
        step();
        txn(k, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, w);
        txn(k, 1'b0, 32'h0000, 32'h0, 4'hF, w);
        @(negedge clk);
        chk("wrap_rdata", k, bus_rsp[k].rdata, 32'h5A5A5A5A);
        step();
      end
      1: begin
        txn(k, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, w);
        chk("wait3_wr", k, 32'(w), 32'h3);
        repeat (3) step();
        txn(k, 1'b0, 32'h40, 32'h0, 4'hF, w);
        chk("wait3_rd", k, 32'(w), 32'h3);
        @(negedge clk);
        chk("lat2_early", k, 32'(bus_rsp[k].rvalid), 32'h0);
        step();
        @(negedge clk);
        chk("lat2_rvalid", k, 32'(bus_rsp[k].rvalid), 32'h1);
        chk("lat2_rdata", k, bus_rsp[k].rdata, 32'hCAFEF00D);
        step();
        for (int i = 0; i < 4; i++) begin
          txn(k, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF, w);
          chk("b2b_wait", k, 32'(w), 32'h3);
        end
        repeat (4) step();
      end
      2: begin
        for (int i = 0; i < 8; i++) txn(k, 1'b1, 32'(4 * i), 32'(i), 4'hF, w);
        repeat (6) step();
        s = cyc;
        log_on = 1'b1;
        for (int i = 0; i < 8; i++) txn(k, 1'b0, 32'(4 * i), 32'h0, 4'hF, w);
        repeat (8) step();
        log_on = 1'b0;
        chk("tput_count", k, 32'(log_c.size()), 32'h8);
        for (int i = 0; i < 8 && i < log_c.size(); i++) begin
          chk("tput_cycle", k, 32'(log_c[i]), 32'(s + 4 + i));
          chk("tput_rdata", k, log_d[i], 32'(i));
        end
      end
      default: begin
        txn(k, 1'b1, 32'h8, 32'h12345678, 4'hF, w);
        repeat (4) step();
        txn(k, 1'b0, 32'h8, 32'h0, 4'hF, w);
        txn(k, 1'b0, 32'h8, 32'h0, 4'hF, w);
        rst_n[k]         = 1'b0;
        bus_req[k].req   = 1'b1;
        bus_req[k].we    = 1'b1;
        bus_req[k].addr  = 32'h8;
        bus_req[k].wdata = 32'hFFFFFFFF;
        bus_req[k].be    = 4'hF;
        @(negedge clk);
        chk("gnt_in_rst", k, 32'(bus_rsp[k].gnt), 32'h0);
        step();
        rst_n[k]       = 1'b1;
        bus_req[k].req = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("flushed_rvalid", k, 32'(bus_rsp[k].rvalid), 32'h0);
          step();
        end
        txn(k, 1'b0, 32'h8, 32'h0, 4'hF, w);
        repeat (2) step();
        @(negedge clk);
        chk("kept_rdata", k, bus_rsp[k].rdata, 32'h12345678);
        step();
      end
    endcase

    // Random traffic with idles, abandoned requests and reset pulses.
    repeat (NRAND) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n[k]         = 1'b0;
        bus_req[k].req   = 1'($urandom_range(0, 1));
        bus_req[k].we    = 1'($urandom_range(0, 1));
        bus_req[k].addr  = $urandom;
        bus_req[k].wdata = $urandom;
        bus_req[k].be    = 4'($urandom);
        step();
        rst_n[k]       = 1'b1;
        bus_req[k].req = 1'b0;
      end else if (r < 15 && gw_of(k) > 0) begin
        bus_req[k].req  = 1'b1;
        bus_req[k].we   = 1'($urandom_range(0, 1));
        bus_req[k].addr = $urandom;
        repeat ($urandom_range(1, gw_of(k))) step();
        bus_req[k].req = 1'b0;
      end else if (r < 30) begin
        bus_req[k].req  = 1'b0;
        bus_req[k].addr = $urandom;
        repeat ($urandom_range(1, 3)) step();
      end else begin
        txn(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), w);
      end
    end
    repeat (6) step();
  endtask

  initial begin
    for (int k = 0; k < N_CFG; k++) begin
      rst_n[k]   = 1'b0;
      bus_req[k] = '0;
      waited[k]  = 0;
      live[k]    = 1'b0;
      for (int s = 0; s < 8; s++) begin
        exp_v[k][s] = 1'b0;
        exp_d[k][s] = 32'h0;
      end
    end
    fork
      run_cfg(0);
      run_cfg(1);
      run_cfg(2);
      run_cfg(3);
    join
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cfg-all: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
